// File: rtl/axi_lite_slave.sv
// AXI4-Lite register slave: NREGS x 32-bit registers with byte-strobed writes.
// Independent write (W_IDLE/W_RESP) and read (R_IDLE/R_DATA) state machines.
// Optional macro AXIL_SLAVE_DECERR_EN: out-of-range accesses answer DECERR
// instead of OKAY.
module axi_lite_slave #(
  parameter int unsigned NREGS     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [31:0] AWADDR,
  input  logic [2:0]  AWPROT,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WVALID,
  output logic        WREADY,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY,
  input  logic [31:0] ARADDR,
  input  logic [2:0]  ARPROT,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RVALID,
  input  logic        RREADY
);

  localparam int unsigned IDX_W = $clog2(NREGS);
  localparam int unsigned SPAN  = 4 * NREGS;

`ifdef AXIL_SLAVE_DECERR_EN
  localparam logic [1:0] OOR_RESP = 2'b11;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  logic [31:0] regs_q [NREGS];

  w_state_e    w_state_q, w_state_d;
  logic        aw_lat_q, aw_lat_d, w_lat_q, w_lat_d;
  logic [31:0] aw_addr_q, aw_addr_d, w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic        awready_q, awready_d, wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;

  r_state_e    r_state_q, r_state_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  logic             aw_hs_c, w_hs_c, ar_hs_c, wr_en_c;
  logic [31:0]      wr_addr_c, wr_data_c, wr_off_c, rd_off_c;
  logic [3:0]       wr_strb_c;
  logic             wr_hit_c, rd_hit_c;
  logic [IDX_W-1:0] wr_idx_c, rd_idx_c;
  logic             unused_prot_c;

  assign unused_prot_c = ^{AWPROT, ARPROT};

  // Commit operands come from the latch if that channel arrived earlier, else live.
  assign wr_addr_c = aw_lat_q ? aw_addr_q : AWADDR;
  assign wr_data_c = w_lat_q  ? w_data_q  : WDATA;
  assign wr_strb_c = w_lat_q  ? w_strb_q  : WSTRB;
  assign wr_off_c  = wr_addr_c - BASE_ADDR;
  assign wr_hit_c  = wr_off_c < 32'(SPAN);
  assign wr_idx_c  = wr_off_c[IDX_W+1:2];
  assign rd_off_c  = ARADDR - BASE_ADDR;
  assign rd_hit_c  = rd_off_c < 32'(SPAN);
  assign rd_idx_c  = rd_off_c[IDX_W+1:2];

  assign aw_hs_c = AWVALID & awready_q;
  assign w_hs_c  = WVALID & wready_q;
  assign ar_hs_c = ARVALID & arready_q;

  // Write FSM next state: pair AW and W in any order, then hold B until taken.
  always_comb begin
    w_state_d = w_state_q;
    aw_lat_d  = aw_lat_q;
    aw_addr_d = aw_addr_q;
    w_lat_d   = w_lat_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wr_en_c   = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_c) begin
          aw_lat_d  = 1'b1;
          aw_addr_d = AWADDR;
        end
        if (w_hs_c) begin
          w_lat_d  = 1'b1;
          w_data_d = WDATA;
          w_strb_d = WSTRB;
        end
        if ((aw_hs_c || aw_lat_q) && (w_hs_c || w_lat_q)) begin
          wr_en_c   = 1'b1;
          aw_lat_d  = 1'b0;
          w_lat_d   = 1'b0;
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = wr_hit_c ? 2'b00 : OOR_RESP;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_lat_d;
    wready_d  = (w_state_d == W_IDLE) && !w_lat_d;
  end

  // Read FSM next state: capture on the AR handshake, hold R until taken.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_c) begin
          r_state_d = R_DATA;
          rvalid_d  = 1'b1;
          rdata_d   = rd_hit_c ? regs_q[rd_idx_c] : 32'h0;
          rresp_d   = rd_hit_c ? 2'b00 : OOR_RESP;
        end
      end
      R_DATA: begin
        if (RREADY) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  // State and output registers for both FSMs.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_state_q <= W_IDLE;
      aw_lat_q  <= 1'b0;
      aw_addr_q <= 32'h0;
      w_lat_q   <= 1'b0;
      w_data_q  <= 32'h0;
      w_strb_q  <= 4'h0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      rresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      aw_lat_q  <= aw_lat_d;
      aw_addr_q <= aw_addr_d;
      w_lat_q   <= w_lat_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Register file: byte-lane writes on commit; reads elsewhere see the old value.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int r = 0; r < int'(NREGS); r++) regs_q[r] <= 32'h0;
    end else if (wr_en_c && wr_hit_c) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb_c[i]) regs_q[wr_idx_c][8*i +: 8] <= wr_data_c[8*i +: 8];
      end
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_lite_slave.sv
// Randomized bench for axi_lite_slave against an array-based register model.
module tb_axi_lite_slave;

  localparam int unsigned NREGS = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;

`ifdef AXIL_SLAVE_DECERR_EN
  localparam logic [1:0] OOR = 2'b11;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  logic        ACLK, ARESETN;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model [NREGS];

  axi_lite_slave #(.NREGS(NREGS), .BASE_ADDR(BASE)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic bit m_hit(input logic [31:0] addr);
    return (addr - BASE) < 32'(4 * NREGS);
  endfunction

  function automatic logic [1:0] m_resp(input logic [31:0] addr);
    return m_hit(addr) ? 2'b00 : OOR;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] addr);
    if (!m_hit(addr)) return 32'h0;
    return model[int'((addr - BASE) >> 2)];
  endfunction

  function automatic void m_write(input logic [31:0] addr, input logic [31:0] data,
                                  input logic [3:0] strb);
    if (!m_hit(addr)) return;
    for (int i = 0; i < 4; i++)
      if (strb[i]) model[int'((addr - BASE) >> 2)][8*i +: 8] = data[8*i +: 8];
  endfunction

  function automatic void m_clear();
    for (int r = 0; r < int'(NREGS); r++) model[r] = 32'h0;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    int cyc = 0;
    logic [1:0] exp_resp;
    exp_resp = m_resp(addr);
    AWADDR = addr; WDATA = data; WSTRB = strb;
    AWPROT = 3'($urandom); 
    while (!(aw_done && w_done) && cyc < 40) begin
      AWVALID = !aw_done && (cyc >= aw_dly);
      WVALID  = !w_done && (cyc >= w_dly);
      hs_aw = AWVALID && AWREADY;
      hs_w  = WVALID && WREADY;
      tick();
      cyc++;
      aw_done |= hs_aw;
      w_done  |= hs_w;
      if (!(aw_done && w_done)) begin
        if (aw_done) check("awready_while_latched", 32'(AWREADY), 32'd0);
        if (w_done)  check("wready_while_latched", 32'(WREADY), 32'd0);
        check("bvalid_before_pair", 32'(BVALID), 32'd0);
      end
    end
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    check("write_handshakes", 32'(aw_done && w_done), 32'd1);
    if (aw_done && w_done) begin
      check("bvalid_after_commit", 32'(BVALID), 32'd1);
      check("bresp", 32'(BRESP), 32'(exp_resp));
      repeat (b_dly) begin
        tick();
        check("bvalid_hold", 32'(BVALID), 32'd1);
        check("bresp_hold", 32'(BRESP), 32'(exp_resp));
        check("awready_in_resp", 32'(AWREADY), 32'd0);
        check("wready_in_resp", 32'(WREADY), 32'd0);
      end
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
      check("bvalid_after_b_hs", 32'(BVALID), 32'd0);
      m_write(addr, data, strb);
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input int ar_dly, input int r_dly);
    bit done = 0, hs;
    int cyc = 0;
    ARADDR = addr;
    ARPROT = 3'($urandom);
    while (!done && cyc < 40) begin
      ARVALID = (cyc >= ar_dly);
      hs = ARVALID && ARREADY;
      if (!ARVALID) check("rvalid_idle", 32'(RVALID), 32'd0);
      tick();
      cyc++;
      done = hs;
    end
    ARVALID = 1'b0;
    check("read_handshake", 32'(done), 32'd1);
    if (done) begin
      check("rvalid_after_ar", 32'(RVALID), 32'd1);
      check("rdata", RDATA, exp_data);
      check("rresp", 32'(RRESP), 32'(exp_resp));
      repeat (r_dly) begin
        tick();
        check("rvalid_hold", 32'(RVALID), 32'd1);
        check("rdata_hold", RDATA, exp_data);
        check("rresp_hold", 32'(RRESP), 32'(exp_resp));
        check("arready_in_data", 32'(ARREADY), 32'd0);
      end
      RREADY = 1'b1;
      tick();
      RREADY = 1'b0;
      check("rvalid_after_r_hs", 32'(RVALID), 32'd0);
    end
  endtask

  task automatic read_all();
    for (int r = 0; r < int'(NREGS); r++) begin
      axi_read(BASE + 32'(4 * r), m_read(BASE + 32'(4 * r)), 2'b00, 0, 0);
    end
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    ARESETN = 1'b0;
    AWADDR = '0; AWPROT = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b0; ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
    m_clear();
    repeat (3) tick();

    // Reset values
    check("rst_awready", 32'(AWREADY), 32'd0);
    check("rst_wready", 32'(WREADY), 32'd0);
    check("rst_arready", 32'(ARREADY), 32'd0);
    check("rst_bvalid", 32'(BVALID), 32'd0);
    check("rst_bresp", 32'(BRESP), 32'd0);
    check("rst_rvalid", 32'(RVALID), 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    check("rst_rresp", 32'(RRESP), 32'd0);
    ARESETN = 1'b1;
    tick();
    check("post_rst_awready", 32'(AWREADY), 32'd1);
    check("post_rst_wready", 32'(WREADY), 32'd1);
    check("post_rst_arready", 32'(ARREADY), 32'd1);

    // Same-cycle AW/W write then read back
    axi_write(BASE + 32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    axi_read(BASE + 32'h4, 32'hDEADBEEF, 2'b00, 0, 0);

    // W leads AW by three cycles with partial strobes
    axi_write(BASE + 32'h8, 32'h11223344, 4'hF, 0, 0, 0);
    axi_write(BASE + 32'h8, 32'hAABBCCDD, 4'b0101, 3, 0, 0);
    axi_read(BASE + 32'h8, 32'h11BB33DD, 2'b00, 0, 0);

    // Back-pressure on B and R for five cycles
    axi_write(BASE + 32'hC, 32'h0BADF00D, 4'hF, 0, 2, 5);
    axi_read(BASE + 32'hC, 32'h0BADF00D, 2'b00, 1, 5);

    // Zero strobe leaves the register untouched
    axi_write(BASE + 32'h8, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
    axi_read(BASE + 32'h8, 32'h11BB33DD, 2'b00, 0, 0);

    // First address past the register window
    axi_write(BASE + 32'(4 * NREGS), 32'hCAFEF00D, 4'hF, 0, 0, 1);
    axi_read(BASE + 32'(4 * NREGS), 32'h0, OOR, 0, 1);
    read_all();

    // Randomized traffic including out-of-range addresses and unaligned low bits
    for (int it = 0; it < 80; it++) begin
      a = BASE + (32'($urandom_range(0, NREGS + 3)) << 2) + 32'($urandom_range(0, 3));
      d = $urandom;
      s = 4'($urandom);
      if ($urandom_range(0, 1) == 1)
        axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(a, m_read(a), m_resp(a), $urandom_range(0, 2), $urandom_range(0, 3));
    end
    read_all();

    // Same-edge write commit and read capture of one register
    axi_write(BASE + 32'h4, 32'h3, 4'hF, 0, 0, 0);
    AWADDR = BASE + 32'h4; WDATA = 32'h5; WSTRB = 4'hF; ARADDR = BASE + 32'h4;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    check("collide_readies", 32'({AWREADY, WREADY, ARREADY}), 32'h7);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    check("collide_rvalid", 32'(RVALID), 32'd1);
    check("collide_bvalid", 32'(BVALID), 32'd1);
    check("collide_rdata_old", RDATA, 32'h3);
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    BREADY = 1'b0; RREADY = 1'b0;
    check("collide_b_done", 32'(BVALID), 32'd0);
    check("collide_r_done", 32'(RVALID), 32'd0);
    m_write(BASE + 32'h4, 32'h5, 4'hF);
    axi_read(BASE + 32'h4, 32'h5, 2'b00, 0, 0);

    // Reset with B and R responses pending
    AWADDR = BASE + 32'h10; WDATA = 32'h12345678; WSTRB = 4'hF; ARADDR = BASE + 32'h4;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    check("pend_bvalid", 32'(BVALID), 32'd1);
    check("pend_rvalid", 32'(RVALID), 32'd1);
    ARESETN = 1'b0;
    tick();
    ARESETN = 1'b1;
    m_clear();
    check("rst2_bvalid", 32'(BVALID), 32'd0);
    check("rst2_rvalid", 32'(RVALID), 32'd0);
    check("rst2_awready", 32'(AWREADY), 32'd0);
    check("rst2_arready", 32'(ARREADY), 32'd0);
    tick();
    check("rst2_readies_up", 32'({AWREADY, WREADY, ARREADY}), 32'h7);

    // Reset with only AW latched: a later lone W must not complete a write
    AWADDR = BASE + 32'h14; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    check("aw_latched", 32'(AWREADY), 32'd0);
    ARESETN = 1'b0;
    tick();
    ARESETN = 1'b1;
    tick();
    check("aw_latch_cleared", 32'(AWREADY), 32'd1);
    WDATA = 32'hFEEDFACE; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    repeat (4) begin
      tick();
      check("no_stray_bvalid", 32'(BVALID), 32'd0);
    end
    ARESETN = 1'b0;
    tick();
    ARESETN = 1'b1;
    tick();
    read_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_slave.md
AXI_LITE_SLAVE -- requirements
Module: axi_lite_slave

Interface
REQ-001 SHALL have parameter: NREGS, 16, number of 32-bit registers (power of 2, 2..256).
REQ-002 SHALL have parameter: BASE_ADDR, 32'h0000_0000, byte address of register 0.
REQ-003 SHALL have port: ACLK  in  1  clock; all logic updates on its rising edge.
REQ-004 SHALL have port: ARESETN  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports: AWADDR in 32; AWPROT in 3 (ignored); AWVALID in 1; AWREADY out 1 (write address channel).
REQ-006 SHALL have ports: WDATA in 32; WSTRB in 4 (byte lane enables); WVALID in 1; WREADY out 1 (write data channel).
REQ-007 SHALL have ports: BRESP out 2; BVALID out 1; BREADY in 1 (write response channel).
REQ-008 SHALL have ports: ARADDR in 32; ARPROT in 3 (ignored); ARVALID in 1; ARREADY out 1 (read address channel).
REQ-009 SHALL have ports: RDATA out 32; RRESP out 2; RVALID out 1; RREADY in 1 (read data channel).

Function
REQ-010 SHALL decode register index = (addr - BASE_ADDR)[log2(NREGS)+1:2]; addr[1:0] ignored; in-range iff 0 <= addr - BASE_ADDR < 4*NREGS.
REQ-011 SHALL implement write FSM states W_IDLE and W_RESP; read FSM states R_IDLE and R_DATA; the two FSMs are independent.
REQ-012 SHALL assert AWREADY in W_IDLE while no AW is latched, and WREADY in W_IDLE while no W is latched; AW and W are accepted in any order or on the same edge.
REQ-013 SHALL hold a latched AW or W until its partner arrives; no further handshake occurs on the latched channel meanwhile.
REQ-014 SHALL, on the edge completing the AW/W pair, write each byte lane i with WSTRB[i]=1 (in-range only), clear both latches, enter W_RESP and assert BVALID.
REQ-015 SHALL hold BVALID and BRESP stable until BVALID&BREADY, then return to W_IDLE with BVALID=0 on that edge; AWREADY/WREADY are 0 throughout W_RESP.
REQ-016 SHALL assert ARREADY only in R_IDLE; on ARVALID&ARREADY, capture the register (or 0 if out-of-range) into RDATA, assert RVALID and enter R_DATA on the same edge (1-cycle latency).
REQ-017 SHALL hold RVALID, RDATA and RRESP stable until RVALID&RREADY, then return to R_IDLE with RVALID=0.
REQ-018 SHALL, when a read capture and a write commit hit the same register on the same edge, return the pre-write value.
REQ-019 SHALL treat WSTRB=4'h0 as a legal write that changes no register and returns a normal response.
REQ-020 SHALL never drop VALID without a handshake, and never depend on READY before asserting VALID.

Reset
REQ-021 SHALL, while ARESETN=0 at a rising edge, clear all registers to 0, both latches, and force W_IDLE and R_IDLE.
REQ-022 SHALL reset outputs to: AWREADY=0, WREADY=0, ARREADY=0, BVALID=0, BRESP=2'b00, RVALID=0, RDATA=0, RRESP=2'b00; READY signals rise on the first edge after ARESETN returns to 1.
REQ-023 SHALL abandon any in-flight transaction (latched AW/W, pending B or R) on reset with no response issued.

Configuration
REQ-024 SHALL, with macro AXIL_SLAVE_DECERR_EN defined, return BRESP/RRESP=2'b11 (DECERR) for out-of-range accesses; in-range accesses return 2'b00.
REQ-025 SHALL, without AXIL_SLAVE_DECERR_EN, return 2'b00 (OKAY) for all accesses; out-of-range writes are discarded and reads return 32'h0.

Verification
REQ-026 SHALL cover: AW=0x04 and W=0xDEADBEEF, WSTRB=4'hF same cycle, BREADY=1 -> BVALID next cycle, BRESP=00; read 0x04 -> RDATA=0xDEADBEEF one cycle after AR handshake.
REQ-027 SHALL cover: W before AW by 3 cycles (reg 2=0x11223344, WSTRB=4'b0101, data 0xAABBCCDD) -> WREADY low after accept, write on AW edge, read returns 0x11BB33DD.
REQ-028 SHALL cover: BREADY and RREADY held low 5 cycles -> BVALID/RVALID, BRESP/RRESP, RDATA stable; AWREADY/WREADY/ARREADY stay 0.
REQ-029 SHALL cover: access to BASE_ADDR+4*NREGS -> RRESP/BRESP=11 with AXIL_SLAVE_DECERR_EN, 00 and RDATA=0 without; no register changed.
REQ-030 SHALL cover: same-edge write 0x5 and read of reg 1 holding 0x3 -> RDATA=0x3, subsequent read 0x5.
REQ-031 SHALL cover: ARESETN low for 1 cycle while BVALID=1 and AW latched -> all VALIDs 0, registers read back 0, no stray B response.
